// File: rtl/ad9914_cmd_parser.sv
// Framed sweep-command parser: hunts 0xAA 0x55, checks CMD/CSUM, issues params with a hold-until-busy update.
// AD9914_CMD_CHECKSUM_EN enables the CSUM compare; without it the 22nd byte is consumed but ignored.
module ad9914_cmd_parser #(
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100000,
   parameter logic [15:0] UPDATE_HOLD_MAX = 16'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        ctrl_busy,
   input  logic        ctrl_finish,
   output logic        update,
   output logic [31:0] lower_limit,
   output logic [31:0] upper_limit,
   output logic [31:0] positive_step,
   output logic [15:0] positive_rate,
   output logic [31:0] resweep_period,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [7:0]  err_count
);
   typedef struct packed {
      logic [31:0] lower;
      logic [31:0] upper;
      logic [31:0] step;
      logic [15:0] rate;
      logic [31:0] period;
   } params_t;

   typedef enum logic [2:0] {S_HUNT0, S_HUNT1, S_CMD, S_PAYLOAD, S_CSUM} rx_state_t;
   typedef enum logic [1:0] {I_IDLE, I_WAIT, I_HOLD} is_state_t;

   rx_state_t   r_rx_state, w_rx_next;
   is_state_t   r_is_state, w_is_next;
   logic [31:0] r_gap;
   logic [4:0]  r_idx;
   params_t     r_shadow, r_pending, r_out;
   logic        r_pend_vld, r_frame_ok, r_frame_err;
   logic [15:0] r_hold;
   logic [7:0]  r_err_count;
   logic        w_timeout, w_csum_ok, w_fok, w_ferr;
   logic        w_ctrl_rdy, w_load, w_hold_to, w_hold_exp;
   logic [8:0]  w_err_sum;

   assign w_timeout = (r_rx_state != S_HUNT0) && (r_gap > TIMEOUT_CYCLES);

`ifdef AD9914_CMD_CHECKSUM_EN
   logic [7:0] r_sum;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum <= '0;
      end else if (rx_valid && !w_timeout) begin
         if (r_rx_state == S_CMD)
            r_sum <= rx_data;
         else if (r_rx_state == S_PAYLOAD)
            r_sum <= r_sum + rx_data;
      end
   end
   assign w_csum_ok = (rx_data == r_sum);
`else
   assign w_csum_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_rx_state <= S_HUNT0;
      else     r_rx_state <= w_rx_next;
   end

   // A timeout wins over a byte arriving in the same cycle; the frame is already dead.
   always_comb begin
      w_rx_next = r_rx_state;
      w_fok     = 1'b0;
      w_ferr    = 1'b0;
      if (w_timeout) begin
         w_rx_next = S_HUNT0;
         w_ferr    = 1'b1;
      end else if (rx_valid) begin
         case (r_rx_state)
            S_HUNT0: begin
               if (rx_data == 8'hAA) w_rx_next = S_HUNT1;
            end
            S_HUNT1: begin
               if (rx_data == 8'h55)      w_rx_next = S_CMD;
               else if (rx_data != 8'hAA) w_rx_next = S_HUNT0;
            end
            S_CMD: begin
               if (rx_data == 8'h01) begin
                  w_rx_next = S_PAYLOAD;
               end else begin
                  w_rx_next = S_HUNT0;
                  w_ferr    = 1'b1;
               end
            end
            S_PAYLOAD: begin
               if (r_idx == 5'd17) w_rx_next = S_CSUM;
            end
            S_CSUM: begin
               w_rx_next = S_HUNT0;
               w_fok     = w_csum_ok;
               w_ferr    = !w_csum_ok;
            end
            default: w_rx_next = S_HUNT0;
         endcase
      end
   end

   assign w_ctrl_rdy = ctrl_finish && !ctrl_busy;
   assign w_hold_exp = ({1'b0, r_hold} + 17'd1) >= {1'b0, UPDATE_HOLD_MAX};

   always_ff @(posedge clk) begin
      if (rst) r_is_state <= I_IDLE;
      else     r_is_state <= w_is_next;
   end

   // With the controller already idle, I_IDLE loads directly so update rises two cycles after CSUM.
   always_comb begin
      w_is_next = r_is_state;
      w_load    = 1'b0;
      w_hold_to = 1'b0;
      case (r_is_state)
         I_IDLE: begin
            if (r_pend_vld) begin
               if (w_ctrl_rdy) begin
                  w_load    = 1'b1;
                  w_is_next = I_HOLD;
               end else begin
                  w_is_next = I_WAIT;
               end
            end
         end
         I_WAIT: begin
            if (w_ctrl_rdy) begin
               w_load    = 1'b1;
               w_is_next = I_HOLD;
            end
         end
         I_HOLD: begin
            if (ctrl_busy) begin
               w_is_next = I_IDLE;
            end else if (w_hold_exp) begin
               w_hold_to = 1'b1;
               w_is_next = I_IDLE;
            end
         end
         default: w_is_next = I_IDLE;
      endcase
   end

   assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_ferr} + {8'd0, w_hold_to};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gap       <= '0;
         r_idx       <= '0;
         r_shadow    <= '0;
         r_pending   <= '0;
         r_pend_vld  <= 1'b0;
         r_out       <= '0;
         r_hold      <= '0;
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_frame_ok  <= w_fok;
         r_frame_err <= w_ferr;
         if (rx_valid || w_timeout || r_rx_state == S_HUNT0)
            r_gap <= '0;
         else
            r_gap <= r_gap + 32'd1;
         if (rx_valid && !w_timeout) begin
            if (r_rx_state == S_CMD) begin
               r_idx <= '0;
            end else if (r_rx_state == S_PAYLOAD) begin
               r_idx    <= r_idx + 5'd1;
               r_shadow <= params_t'({r_shadow[135:0], rx_data});
            end
         end
         // A new frame landing on the load edge keeps the flag set: last frame wins.
         if (w_fok) begin
            r_pending  <= r_shadow;
            r_pend_vld <= 1'b1;
         end else if (w_load) begin
            r_pend_vld <= 1'b0;
         end
         if (w_load) begin
            r_out  <= r_pending;
            r_hold <= '0;
         end else if (r_is_state == I_HOLD) begin
            r_hold <= r_hold + 16'd1;
         end
         r_err_count <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];
      end
   end

   assign update         = (r_is_state == I_HOLD);
   assign lower_limit    = r_out.lower;
   assign upper_limit    = r_out.upper;
   assign positive_step  = r_out.step;
   assign positive_rate  = r_out.rate;
   assign resweep_period = r_out.period;
   assign frame_ok       = r_frame_ok;
   assign frame_err      = r_frame_err;
   assign err_count      = r_err_count;
endmodule

// File: tb/tb_ad9914_cmd_parser.sv
// Bench for ad9914_cmd_parser: vector table, directed timing/handshake sequences, random frames vs a byte-level model.
`timescale 1ns/1ps
module tb_ad9914_cmd_parser;
   localparam int TO = 20;
   localparam int HM = 16;
`ifdef AD9914_CMD_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] lower;
      logic [31:0] upper;
      logic [31:0] step;
      logic [15:0] rate;
      logic [31:0] period;
   } prm_t;

   typedef struct {
      int         pre_aa;
      logic [7:0] cmd;
      logic [7:0] csum_delta;
      int         nbytes;
      prm_t       p;
      bit         exp_ok;
      bit         exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        ctrl_busy = 1'b0;
   logic        ctrl_finish = 1'b1;
   logic        update, frame_ok, frame_err;
   logic [31:0] lower_limit, upper_limit, positive_step, resweep_period;
   logic [15:0] positive_rate;
   logic [7:0]  err_count;
   prm_t        dut_p;

   ad9914_cmd_parser #(.TIMEOUT_CYCLES(32'd20), .UPDATE_HOLD_MAX(16'd16)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .ctrl_busy(ctrl_busy), .ctrl_finish(ctrl_finish), .update(update),
      .lower_limit(lower_limit), .upper_limit(upper_limit), .positive_step(positive_step),
      .positive_rate(positive_rate), .resweep_period(resweep_period),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count)
   );

   always #5 clk = ~clk;
   assign dut_p = {lower_limit, upper_limit, positive_step, positive_rate, resweep_period};

   int   checks = 0, failures = 0;
   int   cnt_ok = 0, cnt_err = 0, cnt_upd = 0, hi_len = 0, unstable = 0, both = 0;
   prm_t cap = '0;
   logic upd_prev = 1'b0;

   always @(negedge clk) begin
      if (frame_ok) cnt_ok++;
      if (frame_err) cnt_err++;
      if (frame_ok && frame_err) both++;
      if (update && !upd_prev) begin
         cnt_upd++;
         cap    = dut_p;
         hi_len = 0;
      end
      if (update) begin
         hi_len++;
         if (dut_p != cap) unstable++;
      end
      upd_prev = update;
   end

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      repeat (gap) tick();
   endtask

   function automatic logic [175:0] mk_frame(input logic [7:0] cmd, input prm_t p, input logic [7:0] delta);
      logic [151:0] body;
      logic [7:0]   s;
      body = {cmd, p};
      s = 8'h00;
      for (int i = 0; i < 19; i++) s = s + body[151-8*i -: 8];
      return {8'hAA, 8'h55, body, 8'(s + delta)};
   endfunction

   task automatic send_frame(input logic [175:0] f, input int nbytes, input int gap);
      for (int i = 0; i < nbytes; i++)
         send_byte(f[175-8*i -: 8], (i == nbytes - 1) ? 0 : gap);
   endtask

   // Reference: a complete 22-byte frame is accepted iff header, CMD and (optionally) the byte sum agree.
   function automatic bit model_parse(input logic [175:0] f, output prm_t p);
      logic [7:0] b [22];
      int s;
      for (int i = 0; i < 22; i++) b[i] = f[175-8*i -: 8];
      s = 0;
      for (int i = 2; i < 21; i++) s += int'(b[i]);
      p = '0;
      for (int i = 0; i < 18; i++) p = {p[135:0], b[3+i]};
      return (b[0] == 8'hAA) && (b[1] == 8'h55) && (b[2] == 8'h01) &&
             (!CSUM_EN || (s % 256) == int'(b[21]));
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic ack();
      ctrl_busy = 1'b1;
      tick();
      ctrl_busy = 1'b0;
      chk("ack_update_fall", update, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: finished=0 required=1");
      $fatal(1, "watchdog");
   end

   initial begin
      prm_t p0, p1, p2, pm, pr;
      logic [175:0] f;
      int b_ok, b_err, b_upd, exp_ec;
      vec_t vt[6];

      p0 = {32'h41E2_4E21, 32'h54B5_57B4, 32'h0000_3158, 16'h0101, 32'h0001_0000};
      p1 = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0100, 16'h0020, 32'h0000_0400};
      p2 = {32'h0BAD_F00D, 32'h7FFF_0001, 32'h0000_0001, 16'hFFFF, 32'h0000_0010};
      vt[0] = '{0, 8'h01, 8'h00, 22, p0, 1'b1, 1'b0};
      vt[1] = '{0, 8'h01, 8'h01, 22, p0, !CSUM_EN, CSUM_EN};
      vt[2] = '{1, 8'h01, 8'h00, 22, p1, 1'b1, 1'b0};
      vt[3] = '{0, 8'h02, 8'h00, 3, p1, 1'b0, 1'b1};
      vt[4] = '{0, 8'h01, 8'h00, 22, '0, 1'b1, 1'b0};
      vt[5] = '{2, 8'h01, 8'h00, 22, p2, 1'b1, 1'b0};
      exp_ec = 0;

      repeat (3) tick();
      chk("rst_update", update, 1'b0);
      chk("rst_frame_ok", frame_ok, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_err_count", err_count, 8'd0);
      chk("rst_params", dut_p, '0);
      rst = 1'b0;
      tick();

      // Cycle-exact: CSUM in cycle N, frame_ok at N+1, update at N+2, falls after busy sampled.
      f = mk_frame(8'h01, p0, 8'h00);
      b_ok = cnt_ok;
      send_frame(f, 21, 0);
      send_byte(f[7:0], 0);
      chk("n1_frame_ok", frame_ok, 1'b1);
      chk("n1_update", update, 1'b0);
      tick();
      chk("n2_update", update, 1'b1);
      chk("n2_params", dut_p, p0);
      chk("n2_frame_ok_pulse", frame_ok, 1'b0);
      repeat (5) tick();
      chk("hold_update", update, 1'b1);
      ack();
      chk("after_params", dut_p, p0);
      chk("directed_ok_count", cnt_ok - b_ok, 1);

      for (int i = 0; i < 6; i++) begin
         b_ok = cnt_ok; b_err = cnt_err; b_upd = cnt_upd;
         repeat (vt[i].pre_aa) send_byte(8'hAA, 0);
         send_frame(mk_frame(vt[i].cmd, vt[i].p, vt[i].csum_delta), vt[i].nbytes, 1);
         repeat (3) tick();
         if (vt[i].exp_err) exp_ec = sat(exp_ec + 1);
         chk($sformatf("vec%0d_ok", i), cnt_ok - b_ok, vt[i].exp_ok);
         chk($sformatf("vec%0d_err", i), cnt_err - b_err, vt[i].exp_err);
         chk($sformatf("vec%0d_upd", i), cnt_upd - b_upd, vt[i].exp_ok);
         chk($sformatf("vec%0d_err_count", i), err_count, exp_ec);
         if (vt[i].exp_ok) begin
            chk($sformatf("vec%0d_params", i), dut_p, vt[i].p);
            ack();
         end
      end

      f = mk_frame(8'h01, p1, 8'h00);
      b_err = cnt_err; b_ok = cnt_ok;
      send_frame(f, 13, 0);
      repeat (TO + 1) tick();
      chk("to_not_early", cnt_err - b_err, 0);
      repeat (3) tick();
      chk("to_frame_err", cnt_err - b_err, 1);
      exp_ec = sat(exp_ec + 1);
      chk("to_err_count", err_count, exp_ec);
      send_frame(f, 22, 0);
      repeat (2) tick();
      chk("to_recover_ok", cnt_ok - b_ok, 1);
      chk("to_recover_params", dut_p, p1);
      ack();

      b_ok = cnt_ok; b_err = cnt_err;
      send_frame(mk_frame(8'h01, p2, 8'h00), 22, TO);
      repeat (2) tick();
      chk("gap_edge_ok", cnt_ok - b_ok, 1);
      chk("gap_edge_err", cnt_err - b_err, 0);
      chk("gap_edge_params", dut_p, p2);
      ack();

      ctrl_busy = 1'b1; ctrl_finish = 1'b0;
      b_ok = cnt_ok; b_upd = cnt_upd;
      send_frame(mk_frame(8'h01, p0, 8'h00), 22, 0);
      send_frame(mk_frame(8'h01, p1, 8'h00), 22, 0);
      repeat (4) tick();
      chk("b2b_ok_count", cnt_ok - b_ok, 2);
      chk("b2b_no_update", cnt_upd - b_upd, 0);
      ctrl_busy = 1'b0; ctrl_finish = 1'b1;
      repeat (2) tick();
      chk("b2b_update", update, 1'b1);
      chk("b2b_params", dut_p, p1);
      ack();
      repeat (4) tick();
      chk("b2b_single_update", cnt_upd - b_upd, 1);

      b_err = cnt_err; b_upd = cnt_upd;
      send_frame(mk_frame(8'h01, p2, 8'h00), 22, 0);
      repeat (HM + 6) tick();
      chk("hto_high_len", hi_len, HM);
      chk("hto_update_low", update, 1'b0);
      exp_ec = sat(exp_ec + 1);
      chk("hto_err_count", err_count, exp_ec);
      chk("hto_no_frame_err", cnt_err - b_err, 0);
      chk("hto_one_update", cnt_upd - b_upd, 1);

      send_frame(mk_frame(8'h01, p1, 8'h00), 22, 0);
      repeat (2) tick();
      chk("rsth_update_before", update, 1'b1);
      rst = 1'b1;
      tick();
      chk("rsth_update_after", update, 1'b0);
      chk("rsth_params", dut_p, '0);
      chk("rsth_err_count", err_count, 8'd0);
      exp_ec = 0;
      send_frame(mk_frame(8'h01, p0, 8'h00), 8, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b_ok = cnt_ok; b_err = cnt_err;
      repeat (TO + 5) tick();
      chk("rstp_no_err", cnt_err - b_err, 0);
      send_frame(mk_frame(8'h01, p2, 8'h00), 22, 0);
      repeat (2) tick();
      chk("rstp_ok", cnt_ok - b_ok, 1);
      chk("rstp_params", dut_p, p2);
      ack();

      for (int it = 0; it < 40; it++) begin
         int kind, gap, nj, nb;
         logic [7:0] cmd, dl, jb;
         bit exp_ok;
         kind = $urandom_range(0, 3);
         gap  = $urandom_range(0, 3);
         nj   = $urandom_range(0, 3);
         pr   = {$urandom, $urandom, $urandom, 16'($urandom), $urandom};
         cmd  = 8'h01; dl = 8'h00; nb = 22;
         if (kind == 2) dl = 8'($urandom_range(1, 255));
         if (kind == 3) begin
            cmd = 8'($urandom_range(2, 255));
            nb  = 3;
         end
         repeat (nj) begin
            do jb = 8'($urandom); while (jb == 8'hAA || jb == 8'h55);
            send_byte(jb, gap);
         end
         f = mk_frame(cmd, pr, dl);
         exp_ok = (nb == 22) && model_parse(f, pm);
         b_ok = cnt_ok; b_err = cnt_err;
         send_frame(f, nb, gap);
         repeat (2) tick();
         if (!exp_ok) exp_ec = sat(exp_ec + 1);
         chk($sformatf("rnd%0d_ok", it), cnt_ok - b_ok, exp_ok);
         chk($sformatf("rnd%0d_err", it), cnt_err - b_err, !exp_ok);
         chk($sformatf("rnd%0d_err_count", it), err_count, exp_ec);
         if (exp_ok) begin
            chk($sformatf("rnd%0d_update", it), update, 1'b1);
            chk($sformatf("rnd%0d_params", it), dut_p, pm);
            ack();
         end
      end

      b_err = cnt_err;
      for (int i = 0; i < 260; i++) send_frame(mk_frame(8'h00, p0, 8'h00), 3, 0);
      repeat (2) tick();
      chk("sat_err_pulses", cnt_err - b_err, 260);
      exp_ec = sat(exp_ec + 260);
      chk("sat_err_count", err_count, exp_ec);

      chk("params_stable_in_update", unstable, 0);
      chk("ok_err_exclusive", both, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
